logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered multi-input logic unit; successor to the fixed 2/3-input gate set.
//  Applies one of eight bitwise functions across up to NUM_IN masked WIDTH-bit operands.
//  Result leaves through a valid/ready output register with zero/parity/all-ones flags.
//  Keeps a saturating count of accepted operations. Sits between a command source and a consumer.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=1)
//  NUM_IN  3  operand count (2..8); any other value is an elaboration error
//  CNT_W   16 width of OP_COUNT (>=1)
// PORTS
//  CLK       in   1             clock, all state on rising edge
//  RST       in   1             asynchronous, active-high reset
//  IN_VALID  in   1             command valid
//  IN_READY  out  1             unit can accept command this cycle
//  IN_OP     in   3             function select (see BEHAVIOUR)
//  IN_EN     in   NUM_IN        operand enable mask; bit k enables operand k
//  IN_DATA   in   NUM_IN*WIDTH  operands; operand k = IN_DATA[k*WIDTH +: WIDTH]
//  OUT_VALID out  1             result valid
//  OUT_READY in   1             consumer accepts result
//  OUT_DATA  out  WIDTH         result
//  OUT_ZERO  out  1             OUT_DATA == 0
//  OUT_PAR   out  1             ^OUT_DATA (odd parity)
//  OUT_ALL1  out  1             &OUT_DATA
//  CNT_CLR   in   1             synchronous clear of OP_COUNT
//  OP_COUNT  out  CNT_W         saturating count of accepted commands
// BEHAVIOUR
//  Reset (async, RST=1): OUT_VALID=0, OUT_DATA=0, OUT_ZERO=1, OUT_PAR=0, OUT_ALL1=0, OP_COUNT=0.
//  Flags are registered together with OUT_DATA, never decoded from a stale value.
//  Accept = IN_VALID & IN_READY. IN_READY = ~OUT_VALID | OUT_READY (combinational, no reset dependency).
//  Latency: accepted command appears on OUT_* the next rising edge; full throughput 1/cycle.
//  Output register: on accept load result, OUT_VALID=1; else if OUT_READY clear OUT_VALID.
//  OUT_DATA/flags hold stable while OUT_VALID & ~OUT_READY.
//  OUT_DATA/flags unchanged when OUT_VALID drops.
//  IN_OP: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 NOT, 5 BUF, 6 XOR, 7 XNOR, all bitwise over enabled operands.
//  Disabled operands take the identity value: all-ones for AND/NAND, zero for OR/NOR/XOR/XNOR.
//  Empty mask (IN_EN=0): AND=all-ones, OR=0, NAND=0, NOR=all-ones, XOR=0, XNOR=all-ones.
//  NOT/BUF use operand 0 only and ignore IN_EN.
//  OP_COUNT: +1 per accept, saturates at 2^CNT_W-1 (no wrap).
//  CNT_CLR=1 sets OP_COUNT=0 next edge; clear wins over simultaneous accept (result 0).
//  Reset mid-transfer discards the held result; IN_READY=1 from the first cycle after RST falls.
//  IN_* are ignored when not accepted; X on IN_DATA with IN_VALID=0 must not propagate.
// TESTING (WIDTH=8, NUM_IN=3, CNT_W=4 unless stated)
//  1 OP=0, EN=111, ops 0xF0/0x3C/0xFF, OUT_READY=1 -> next cycle OUT_DATA=0x30, ZERO=0, PAR=0, ALL1=0.
//  2 OP=6, EN=111, ops 0x0F/0xFF/0x01 -> 0xF1, PAR=1. Same with EN=101 -> 0x0E, PAR=1.
//  3 OP=3, EN=000 -> 0xFF, ALL1=1. OP=4, EN=000, op0=0x5A -> 0xA5.
//  4 OUT_READY=0 for 5 cycles with IN_VALID=1 -> one result held stable, IN_READY=0.
//    Release -> back-to-back results, none lost or duplicated.
//  5 20 accepts -> OP_COUNT=15. Then CNT_CLR with a simultaneous accept -> OP_COUNT=0, next accept -> 1.
//  6 Assert RST while OUT_VALID=1, OUT_READY=0 -> OUT_VALID=0, OUT_ZERO=1, OP_COUNT=0 immediately (async).

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Registered multi-input bitwise logic unit with valid/ready output stage,
// result flags and a saturating count of accepted commands.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [NUM_IN-1:0]       in_en,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_par,
  output logic                    out_all1,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        op_count
);

  if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
    $error("logic_unit_pipe: NUM_IN must be in 2..8");
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_BUF  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  logic             accept;
  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] xor_acc;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] result;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign op0      = in_data[WIDTH-1:0];

  // Disabled operands contribute the identity of each reduction, so an empty
  // mask naturally yields all-ones for AND and zero for OR/XOR.
  always_comb begin
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_en[k]) begin
        and_acc = and_acc & in_data[k*WIDTH +: WIDTH];
        or_acc  = or_acc  | in_data[k*WIDTH +: WIDTH];
        xor_acc = xor_acc ^ in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    case (op_e'(in_op))
      OP_AND:  result = and_acc;
      OP_OR:   result = or_acc;
      OP_NAND: result = ~and_acc;
      OP_NOR:  result = ~or_acc;
      OP_NOT:  result = ~op0;
      OP_BUF:  result = op0;
      OP_XOR:  result = xor_acc;
      OP_XNOR: result = ~xor_acc;
      default: result = '0;
    endcase
  end

  // Data and flags load only on accept, so they stay put while stalled and
  // after the consumer drains the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_par   <= 1'b0;
      out_all1  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_zero  <= (result == '0);
      out_par   <= ^result;
      out_all1  <= &result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (cnt_clr) begin
      op_count <= '0;
    end else if (accept && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed commands, stall/release,
// counter saturation/clear and asynchronous reset mid-transfer.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_en;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_zero;
  logic        out_par;
  logic        out_all1;
  logic        cnt_clr;
  logic [3:0]  op_count;

  int compared   = 0;
  int mismatched = 0;

  logic [10:0] sb_q[$];
  logic [3:0]  exp_cnt = 4'd0;

  logic_unit_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_en     (in_en),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_par   (out_par),
    .out_all1  (out_all1),
    .cnt_clr   (cnt_clr),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-bit model: count enabled ones in each column and decide from the count.
  function automatic logic [10:0] model(input logic [2:0] op, input logic [2:0] en,
                                         input logic [23:0] data);
    logic [7:0] r;
    int n1, ne;
    for (int b = 0; b < 8; b++) begin
      n1 = 0;
      ne = 0;
      for (int k = 0; k < 3; k++) begin
        if (en[k]) begin
          ne++;
          if (data[k*8 + b]) n1++;
        end
      end
      case (op)
        3'd0: r[b] = (n1 == ne);
        3'd1: r[b] = (n1 != 0);
        3'd2: r[b] = (n1 != ne);
        3'd3: r[b] = (n1 == 0);
        3'd4: r[b] = ~data[b];
        3'd5: r[b] = data[b];
        3'd6: r[b] = (n1 % 2 == 1);
        default: r[b] = (n1 % 2 == 0);
      endcase
    end
    return {r, (r == 8'h00), ^r, &r};
  endfunction

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor sampled on the falling edge, away from the active edge.
  initial begin
    logic [10:0] exp_item;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        exp_cnt = 4'd0;
      end else begin
        compare("op_count_track", 32'(op_count), 32'(exp_cnt));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            compare("sb_unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            exp_item = sb_q.pop_front();
            compare("sb_result", {21'd0, out_data, out_zero, out_par, out_all1}, 32'(exp_item));
          end
        end
        if (in_valid && in_ready) sb_q.push_back(model(in_op, in_en, in_data));
        if (cnt_clr) exp_cnt = 4'd0;
        else if (in_valid && in_ready && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic apply_stimulus(input logic [2:0] op, input logic [2:0] en, input logic [23:0] data);
    in_valid = 1'b1;
    in_op    = op;
    in_en    = en;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic check_output(input string tag, input logic valid, input logic [7:0] data,
                              input logic zero, input logic par, input logic all1);
    compare(tag, {20'd0, out_valid, out_data, out_zero, out_par, out_all1},
            {20'd0, valid, data, zero, par, all1});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_en     = 3'd0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_output("reset_outputs", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compare("reset_count", 32'(op_count), 32'd0);
    compare("reset_in_ready", 32'(in_ready), 32'd1);

    apply_stimulus(3'd0, 3'b111, {8'hFF, 8'h3C, 8'hF0});
    check_output("and_3", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd6, 3'b111, {8'h01, 8'hFF, 8'h0F});
    check_output("xor_3", 1'b1, 8'hF1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'd6, 3'b101, {8'h01, 8'hFF, 8'h0F});
    check_output("xor_mask101", 1'b1, 8'h0E, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'd3, 3'b000, {8'h12, 8'h34, 8'h56});
    check_output("nor_empty", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    apply_stimulus(3'd4, 3'b000, {8'h00, 8'h00, 8'h5A});
    check_output("not_op0", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd1, 3'b000, {8'hFF, 8'hFF, 8'hFF});
    check_output("or_empty", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'd2, 3'b011, {8'h00, 8'hF0, 8'hCC});
    check_output("nand_mask011", 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd7, 3'b000, {8'hAA, 8'hBB, 8'hCC});
    check_output("xnor_empty", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    apply_stimulus(3'd5, 3'b000, {8'hAA, 8'hBB, 8'h07});
    check_output("buf_op0", 1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_output("drained_hold", 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);

    // Stall: one result held while the producer keeps offering new commands.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd5;
    in_en     = 3'b000;
    in_data   = {16'h0000, 8'h01};
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_hold", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      compare("stall_in_ready", 32'(in_ready), 32'd0);
      in_data = {16'h0000, 8'(i + 2)};
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_data   = {16'h0000, 8'h0A};
    @(posedge clk);
    #1;
    check_output("release_first", 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    in_data = {16'h0000, 8'h0B};
    @(posedge clk);
    #1;
    in_data = {16'h0000, 8'h0C};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    repeat (2) @(posedge clk);
    #1;

    // Counter saturation and clear-over-accept priority.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    compare("count_cleared", 32'(op_count), 32'd0);
    for (int i = 0; i < 20; i++) apply_stimulus(3'd1, 3'b111, 24'(i * 24'h010203));
    compare("count_saturated", 32'(op_count), 32'd15);
    cnt_clr = 1'b1;
    apply_stimulus(3'd0, 3'b110, {8'h0F, 8'h3C, 8'h00});
    cnt_clr = 1'b0;
    compare("clear_wins", 32'(op_count), 32'd0);
    apply_stimulus(3'd6, 3'b010, {8'h00, 8'h81, 8'h00});
    compare("count_after_clear", 32'(op_count), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    compare("sb_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset with a result held against a stalled consumer.
    out_ready = 1'b0;
    apply_stimulus(3'd5, 3'b000, {16'h0000, 8'h3E});
    check_output("pre_reset_held", 1'b1, 8'h3E, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_outputs", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compare("async_reset_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    compare("post_reset_in_ready", 32'(in_ready), 32'd1);
    check_output("post_reset_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'd0, 3'b111, {8'hFF, 8'hFF, 8'hFF});
    check_output("post_reset_and", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    compare("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
